// File: rtl/pipeline_hazard_controller_if.sv
// ID/EX hazard-control bundle: pipeline-side inputs and the stall/flush/interrupt controls.
// The master drives the pipeline observations; the controller sits on the slave side.
interface pipeline_hazard_controller_if;
    logic [3:0] id_src_addr;
    logic [3:0] id_dst_addr;
    logic       id_uses_src;
    logic       id_uses_dst;
    logic       id_two_word;
    logic       ex_mem_read;
    logic [3:0] ex_dest_addr;
    logic       ex_branch_taken;
    logic       int_req;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       imm_capture;
    logic       int_ack;
    logic [1:0] state;

    modport master (
        output id_src_addr, id_dst_addr, id_uses_src, id_uses_dst, id_two_word,
               ex_mem_read, ex_dest_addr, ex_branch_taken, int_req,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, imm_capture, int_ack, state
    );

    modport slave (
        input  id_src_addr, id_dst_addr, id_uses_src, id_uses_dst, id_two_word,
               ex_mem_read, ex_dest_addr, ex_branch_taken, int_req,
        output pc_write, ifid_write, ifid_flush, idex_bubble, imm_capture, int_ack, state
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flush, two-word immediate capture
// and interrupt drain sequencing.
module pipeline_hazard_controller #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    pipeline_hazard_controller_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMM   = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       int_pend_q, int_pend_d;
    logic       hazard;

    always_comb begin
        hazard = bus.ex_mem_read && (bus.ex_dest_addr != 4'hF) &&
                 ((bus.id_uses_src && (bus.id_src_addr == bus.ex_dest_addr)) ||
                  (bus.id_uses_dst && (bus.id_dst_addr == bus.ex_dest_addr)));
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        int_pend_d      = int_pend_q;
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.imm_capture = 1'b0;
        bus.int_ack     = 1'b0;
        bus.state       = state_q;

        if (!rst_n) begin
            // Outputs hold the pipeline frozen and bubbled for as long as reset is low
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
            bus.state       = RUN;
        end else begin
            if (bus.ex_branch_taken) begin
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
                state_d         = RUN;
                cnt_d           = '0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (hazard) begin
                            bus.pc_write    = 1'b0;
                            bus.ifid_write  = 1'b0;
                            bus.idex_bubble = 1'b1;
                            cnt_d           = STALL_LOAD;
                            state_d         = (STALL_CYCLES > 1) ? STALL : RUN;
                        end else if (int_pend_q) begin
                            state_d = DRAIN;
                            cnt_d   = DRAIN_LOAD;
                        end else if (bus.id_two_word) begin
                            state_d = IMM;
                        end
                    end
                    IMM: begin
                        bus.imm_capture = 1'b1;
                        bus.idex_bubble = 1'b1;
                        state_d         = RUN;
                    end
                    STALL: begin
                        bus.pc_write    = 1'b0;
                        bus.ifid_write  = 1'b0;
                        bus.idex_bubble = 1'b1;
                        cnt_d           = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) state_d = RUN;
                    end
                    DRAIN: begin
                        bus.pc_write    = 1'b0;
                        bus.ifid_write  = 1'b0;
                        bus.ifid_flush  = 1'b1;
                        bus.idex_bubble = 1'b1;
                        cnt_d           = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            bus.int_ack = 1'b1;
                            state_d     = RUN;
                        end
                    end
                endcase
            end
            // A request coinciding with the acknowledge is dropped, not queued
            int_pend_d = bus.int_ack ? 1'b0 : (int_pend_q | bus.int_req);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_pend_q <= int_pend_d;
        end
    end
endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 1, load-use stall length in cycles (legal 1..7).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, interrupt drain length in cycles (legal 1..7).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port id_src_addr  in  4  source register address of the instruction in ID.
REQ-006 SHALL have port id_dst_addr  in  4  destination register address of the instruction in ID.
REQ-007 SHALL have ports id_uses_src, id_uses_dst  in  1 each  ID instruction reads src/dst register.
REQ-008 SHALL have port id_two_word  in  1  ID instruction carries an immediate in the next fetched word.
REQ-009 SHALL have ports ex_mem_read  in  1 and ex_dest_addr  in  4  EX-stage load flag and its destination; 4'hF = bubble/no destination.
REQ-010 SHALL have port ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-011 SHALL have port int_req  in  1  interrupt request, single-cycle pulse.
REQ-012 SHALL have outputs pc_write, ifid_write, ifid_flush, idex_bubble, imm_capture, int_ack  out  1 each: PC update enable, IF/ID load enable, IF/ID clear, ID/EX bubble insert (forces dest/src address 4'hF and clears controls), ID captures current IF/ID word as immediate, interrupt accepted.
REQ-013 SHALL have output state  out  2  FSM state: RUN=0, IMM=1, STALL=2, DRAIN=3.

Function
REQ-014 Outputs SHALL be combinational from state and inputs; state, 3-bit counter cnt and flag int_pend SHALL be registered.
REQ-015 Default (RUN, no event): pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, imm_capture=0, int_ack=0.
REQ-016 hazard SHALL be: ex_mem_read & ex_dest_addr!=4'hF & ((id_uses_src & id_src_addr==ex_dest_addr) | (id_uses_dst & id_dst_addr==ex_dest_addr)); evaluated only in RUN.
REQ-017 Priority per cycle SHALL be: ex_branch_taken > hazard > interrupt entry > id_two_word.
REQ-018 ex_branch_taken in any state: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; next state RUN, cnt=0; int_pend unchanged.
REQ-019 hazard in RUN: pc_write=0, ifid_write=0, idex_bubble=1; if STALL_CYCLES=1 stay RUN, else go STALL with cnt=STALL_CYCLES-1.
REQ-020 STALL: same outputs as REQ-019; cnt decrements each cycle; when cnt==1 next state RUN.
REQ-021 int_pend SHALL set on int_req and clear on int_ack; int_req while pending SHALL be ignored (no queueing).
REQ-022 Interrupt entry: RUN, int_pend=1, no branch, no hazard, id_two_word=0 -> next DRAIN, cnt=DRAIN_CYCLES; the entry cycle itself has default outputs.
REQ-023 DRAIN: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1; cnt decrements; when cnt==1 assert int_ack=1 for that cycle and go RUN.
REQ-024 id_two_word in RUN (no higher event): default outputs; next state IMM.
REQ-025 IMM (exactly one cycle): imm_capture=1, idex_bubble=1, pc_write=1, ifid_write=1; next RUN; hazard and interrupt entry SHALL NOT be evaluated in IMM.
REQ-026 int_req arriving in the same cycle as int_ack SHALL be dropped.

Reset
REQ-027 While rst_n=0 at posedge clk: state=RUN, cnt=0, int_pend=0.
REQ-028 While rst_n=0 outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, imm_capture=0, int_ack=0, state=0.
REQ-029 Reset asserted mid-STALL/DRAIN/IMM SHALL abort the sequence; a pending interrupt is discarded, no int_ack.

Verification
REQ-030 Load-use: ex_mem_read=1, ex_dest_addr=3, id_uses_src=1, id_src_addr=3, STALL_CYCLES=1 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1, then defaults.
REQ-031 No false hazard: ex_mem_read=1, ex_dest_addr=4'hF, id_src_addr=4'hF -> defaults, state stays 0.
REQ-032 Two-word: id_two_word=1 in RUN -> next cycle state=1, imm_capture=1, idex_bubble=1; following cycle state=0.
REQ-033 Interrupt: int_req pulse, DRAIN_CYCLES=3 -> entry cycle defaults, then 3 DRAIN cycles with ifid_flush=1, int_ack=1 in the 3rd only, then RUN.
REQ-034 Branch override: ex_branch_taken=1 during STALL with cnt=2 -> ifid_flush=1, idex_bubble=1, pc_write=1, next state=0.
REQ-035 Reset mid-DRAIN: rst_n=0 one cycle at cnt=2 -> state=0, int_ack never asserts, outputs per REQ-028 during reset.
